// File: rtl/fork_stage.sv
// fork_stage: broadcasts one valid/stall stream into two
// independently stalled branches, each with its own FIFO.
module fork_stage #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         v_i,
  input  logic [W-1:0] data_i,
  output logic         stall_o,
  output logic         v_o1,
  output logic [W-1:0] data_o1,
  input  logic         stall_i1,
  output logic         v_o2,
  output logic [W-1:0] data_o2,
  input  logic         stall_i2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem1 [DEPTH];
  logic [W-1:0]  mem2 [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd1;
  logic [AW-1:0] rd2;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic          push;
  logic          pop1;
  logic          pop2;

  // stall_o looks only at registered counts, never at stall_iN
  assign stall_o = (cnt1 == FULL) | (cnt2 == FULL);
  assign push    = v_i & ~stall_o;

  assign v_o1    = (cnt1 != '0);
  assign v_o2    = (cnt2 != '0);
  assign data_o1 = mem1[rd1];
  assign data_o2 = mem2[rd2];
  assign pop1    = v_o1 & ~stall_i1;
  assign pop2    = v_o2 & ~stall_i2;

  // pushes are broadcast, so one write pointer serves both FIFOs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr   <= '0;
      rd1  <= '0;
      rd2  <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
    end else begin
      if (push) begin
        mem1[wr] <= data_i;
        mem2[wr] <= data_i;
        wr       <= wr + 1'b1;
      end
      if (pop1) rd1 <= rd1 + 1'b1;
      if (pop2) rd2 <= rd2 + 1'b1;
      cnt1 <= cnt1 + CW'(push) - CW'(pop1);
      cnt2 <= cnt2 + CW'(push) - CW'(pop2);
    end
  end

endmodule

// File: tb/tb_fork_stage.sv
// tb_fork_stage: directed vector table, hand sequences and
// a queue-based random reference model for fork_stage.
module tb_fork_stage;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         stall_o;
  logic         v_o1;
  logic [W-1:0] data_o1;
  logic         stall_i1;
  logic         v_o2;
  logic [W-1:0] data_o2;
  logic         stall_i2;

  int tests = 0;
  int fails = 0;

  fork_stage #(.W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .v_i     (v_i),
    .data_i  (data_i),
    .stall_o (stall_o),
    .v_o1    (v_o1),
    .data_o1 (data_o1),
    .stall_i1(stall_i1),
    .v_o2    (v_o2),
    .data_o2 (data_o2),
    .stall_i2(stall_i2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         s1;
    logic         s2;
    logic         ev1;
    logic [W-1:0] ed1;
    logic         ev2;
    logic [W-1:0] ed2;
    logic         est;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic v, logic [W-1:0] d,
                              logic s1, logic s2,
                              logic ev1, logic [W-1:0] ed1,
                              logic ev2, logic [W-1:0] ed2,
                              logic est);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.s1 = s1; r.s2 = s2;
    r.ev1 = ev1; r.ed1 = ed1; r.ev2 = ev2; r.ed2 = ed2;
    r.est = est;
    return r;
  endfunction

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // apply inputs across one rising edge, then sample 1ns later
  task automatic cyc(logic rst, logic v, logic [W-1:0] d,
                     logic s1, logic s2);
    reset    = rst;
    v_i      = v;
    data_i   = d;
    stall_i1 = s1;
    stall_i2 = s2;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  logic [W-1:0] acc[$];
  int           got1;
  int           got2;

  initial begin
    reset = 1'b1; v_i = 1'b0; data_i = '0;
    stall_i1 = 1'b0; stall_i2 = 1'b0;

    // 1: reset held with v_i=1
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 1, 32'hFF, 0, 0, 0, 0, 0, 0, 0));
    // 2: back-to-back pushes, no stalls
    vt.push_back(mk(0, 1, 32'h11, 0, 0, 1, 32'h11, 1, 32'h11, 0));
    vt.push_back(mk(0, 1, 32'h22, 0, 0, 1, 32'h22, 1, 32'h22, 0));
    vt.push_back(mk(0, 1, 32'h33, 0, 0, 1, 32'h33, 1, 32'h33, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0));
    // 3: branch 2 stalled, producer held on A2
    vt.push_back(mk(0, 1, 32'hA0, 0, 1, 1, 32'hA0, 1, 32'hA0, 0));
    vt.push_back(mk(0, 1, 32'hA1, 0, 1, 1, 32'hA1, 1, 32'hA0, 1));
    vt.push_back(mk(0, 1, 32'hA2, 0, 1, 0, 0, 1, 32'hA0, 1));
    vt.push_back(mk(0, 1, 32'hA2, 0, 0, 0, 0, 1, 32'hA1, 0));
    vt.push_back(mk(0, 1, 32'hA2, 0, 0, 1, 32'hA2, 1, 32'hA2, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0));
    // 4: both full, release stalls with 0x55 waiting
    vt.push_back(mk(0, 1, 32'h41, 1, 1, 1, 32'h41, 1, 32'h41, 0));
    vt.push_back(mk(0, 1, 32'h42, 1, 1, 1, 32'h41, 1, 32'h41, 1));
    vt.push_back(mk(0, 1, 32'h55, 0, 0, 1, 32'h42, 1, 32'h42, 0));
    vt.push_back(mk(0, 1, 32'h55, 0, 0, 1, 32'h55, 1, 32'h55, 0));
    vt.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0));

    foreach (vt[i]) begin
      cyc(vt[i].rst, vt[i].v, vt[i].d, vt[i].s1, vt[i].s2);
      check($sformatf("vec%0d.stall_o", i), W'(stall_o), W'(vt[i].est));
      check($sformatf("vec%0d.v_o1", i), W'(v_o1), W'(vt[i].ev1));
      check($sformatf("vec%0d.v_o2", i), W'(v_o2), W'(vt[i].ev2));
      if (vt[i].ev1 || vt[i].rst)
        check($sformatf("vec%0d.data_o1", i), data_o1, vt[i].ed1);
      if (vt[i].ev2 || vt[i].rst)
        check($sformatf("vec%0d.data_o2", i), data_o2, vt[i].ed2);
    end

    // 5: branch 1 holds B1, branch 2 holds B0,B1; reset one cycle
    cyc(0, 1, 32'hB0, 1, 1);
    cyc(0, 1, 32'hB1, 0, 1);
    check("rst5.pre_d1", data_o1, 32'hB1);
    check("rst5.pre_d2", data_o2, 32'hB0);
    check("rst5.pre_stall", W'(stall_o), W'(1'b1));
    cyc(1, 0, 32'h0, 0, 0);
    check("rst5.v_o1", W'(v_o1), '0);
    check("rst5.v_o2", W'(v_o2), '0);
    check("rst5.stall", W'(stall_o), '0);
    check("rst5.d1", data_o1, '0);
    check("rst5.d2", data_o2, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 0, 0);
      check("rst5.idle_v1", W'(v_o1), '0);
      check("rst5.idle_v2", W'(v_o2), '0);
    end

    // 6: random traffic against queue model
    got1 = 0;
    got2 = 0;
    for (int n = 0; n < 10000; n++) begin
      logic         rv, rs1, rs2, mst, mpush, mpop1, mpop2;
      logic [W-1:0] rd;
      mst = (q1.size() == DEPTH) || (q2.size() == DEPTH);
      check("rnd.stall_o", W'(stall_o), W'(mst));
      check("rnd.v_o1", W'(v_o1), W'(q1.size() != 0));
      check("rnd.v_o2", W'(v_o2), W'(q2.size() != 0));
      if (q1.size() != 0) check("rnd.data_o1", data_o1, q1[0]);
      if (q2.size() != 0) check("rnd.data_o2", data_o2, q2[0]);
      rv  = ($urandom_range(0, 3) != 0);
      rs1 = ($urandom_range(0, 9) < 4);
      rs2 = ($urandom_range(0, 9) < 4);
      rd  = $urandom;
      mpush = rv && !mst;
      mpop1 = (q1.size() != 0) && !rs1;
      mpop2 = (q2.size() != 0) && !rs2;
      cyc(0, rv, rd, rs1, rs2);
      if (mpop1) begin void'(q1.pop_front()); got1++; end
      if (mpop2) begin void'(q2.pop_front()); got2++; end
      if (mpush) begin
        q1.push_back(rd);
        q2.push_back(rd);
        acc.push_back(rd);
      end
    end
    check("rnd.total1", W'(got1 + q1.size()), W'(acc.size()));
    check("rnd.total2", W'(got2 + q2.size()), W'(acc.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
